// File: rtl/data_ram_uart_dump_pkg.sv
// data_ram_uart_dump_pkg
//   Shared definitions for the data-RAM UART dump block:
//   - 8N1 frame constants (START_BIT, STOP_BIT, FRAME_BITS)
//   - dump FSM state encoding (3-bit enum)
//   - clks_per_bit(): baud divider derivation (integer-truncated)
package data_ram_uart_dump_pkg;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam int   FRAME_BITS = 10;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_READ_REQ  = 3'd1,
    S_READ_WAIT = 3'd2,
    S_SEND_HI   = 3'd3,
    S_SEND_LO   = 3'd4,
    S_NEXT      = 3'd5,
    S_CHKSUM    = 3'd6,
    S_DONE      = 3'd7
  } dump_state_e;

  // Clock cycles per serial bit. The result must be >= 2 for the
  // transmitter's early-ready logic to be meaningful.
  function automatic int clks_per_bit(input int clk_freq_hz, input int baud_rate);
    return clk_freq_hz / baud_rate;
  endfunction

endpackage

// File: rtl/data_ram_uart_dump_uart_tx_byte.sv
// uart_tx_byte
//   8N1 serial transmitter for one byte per handshake.
//   Ports:
//     i_clk, i_rst   clock, asynchronous active-high reset
//     i_valid        byte offered by the producer
//     i_byte[7:0]    byte to send (LSB first)
//     o_ready        transmitter can accept a byte this cycle
//     o_tx           serial line, idle high
//   Handshake: a byte is accepted on a rising edge where i_valid and
//   o_ready are both high; the producer must hold i_valid/i_byte stable
//   until then. o_ready is also raised during the final cycle of the stop
//   bit, so a byte offered then starts its start bit on the very next
//   cycle with no idle gap between frames.
module uart_tx_byte
  import data_ram_uart_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic [7:0] i_byte,
  output logic       o_ready,
  output logic       o_tx
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic             busy_q;
  logic [CNT_W-1:0] baud_q;
  logic [3:0]       bit_q;    // frame bit currently on the line, 0..9
  logic [8:0]       shift_q;  // remaining data bits plus stop bit
  logic             last_tick;
  logic             accept;

  assign last_tick = (baud_q == CNT_W'(CLKS_PER_BIT - 1));
  assign o_ready   = !busy_q || (last_tick && (bit_q == 4'(FRAME_BITS - 1)));
  assign accept    = i_valid && o_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      busy_q  <= 1'b0;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '1;
      o_tx    <= STOP_BIT;
    end else if (accept) begin
      busy_q  <= 1'b1;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= {STOP_BIT, i_byte};
      o_tx    <= START_BIT;
    end else if (busy_q) begin
      if (last_tick) begin
        baud_q <= '0;
        if (bit_q == 4'(FRAME_BITS - 1)) begin
          busy_q <= 1'b0;
          o_tx   <= STOP_BIT;
        end else begin
          bit_q   <= bit_q + 4'd1;
          o_tx    <= shift_q[0];
          shift_q <= {STOP_BIT, shift_q[8:1]};
        end
      end else begin
        baud_q <= baud_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/data_ram_uart_dump.sv
// data_ram_uart_dump
//   After the CPU halts, walks the data RAM read port from address 0 to
//   the latched last address and sends every 16-bit word over an 8N1 line,
//   high byte first. Owns the RAM read port only while o_busy is high.
//   Ports:
//     i_clk, i_rst   clock, asynchronous active-high reset
//     i_start_dump   single-cycle dump request (ignored while busy)
//     i_last_addr    last address to send, inclusive; sampled at start
//     o_ram_read     RAM read strobe (one cycle per word)
//     o_ram_addr     RAM read address
//     i_ram_data     RAM read data, valid one cycle after o_ram_read
//     o_tx           serial output, idle high
//     o_busy         dump in progress
//     o_done         one-cycle pulse after the final stop bit
//   Build option: DATA_RAM_UART_DUMP_CHECKSUM_EN appends one byte holding
//   the XOR of all transmitted data bytes.
//   Debug: the FSM state is held in state_q (type dump_state_e).
module data_ram_uart_dump
  import data_ram_uart_dump_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int BAUD_RATE   = 115200,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start_dump,
  input  logic [ADDR_W-1:0] i_last_addr,
  output logic              o_ram_read,
  output logic [ADDR_W-1:0] o_ram_addr,
  input  logic [DATA_W-1:0] i_ram_data,
  output logic              o_tx,
  output logic              o_busy,
  output logic              o_done
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);

  dump_state_e       state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] last_q;
  logic [7:0]        lo_byte_q;
  logic [7:0]        tx_byte_q;
  logic              tx_valid_q;
  logic              tx_ready;
  logic              tx_accept;

  assign o_ram_addr = addr_q;
  assign tx_accept  = tx_valid_q && tx_ready;

`ifdef DATA_RAM_UART_DUMP_CHECKSUM_EN
  logic [7:0] chk_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      chk_q <= '0;
    end else if (state_q == S_IDLE && i_start_dump) begin
      chk_q <= '0;
    end else if (tx_accept && (state_q == S_SEND_HI || state_q == S_SEND_LO)) begin
      chk_q <= chk_q ^ tx_byte_q;
    end
  end
`endif

  // Dump sequencer. The next word's read is issued as soon as the low
  // byte has been handed to the transmitter, so it completes while that
  // byte is still on the line and the following high byte is waiting
  // when the transmitter raises its early ready.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      last_q     <= '0;
      lo_byte_q  <= '0;
      tx_byte_q  <= '0;
      tx_valid_q <= 1'b0;
      o_ram_read <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start_dump) begin
            last_q     <= i_last_addr;
            addr_q     <= '0;
            o_busy     <= 1'b1;
            o_ram_read <= 1'b1;
            state_q    <= S_READ_REQ;
          end
        end
        S_READ_REQ: begin
          o_ram_read <= 1'b0;
          state_q    <= S_READ_WAIT;
        end
        S_READ_WAIT: begin
          lo_byte_q  <= i_ram_data[7:0];
          tx_byte_q  <= i_ram_data[DATA_W-1 -: 8];
          tx_valid_q <= 1'b1;
          state_q    <= S_SEND_HI;
        end
        S_SEND_HI: begin
          if (tx_accept) begin
            tx_byte_q <= lo_byte_q;
            state_q   <= S_SEND_LO;
          end
        end
        S_SEND_LO: begin
          if (tx_accept) begin
            tx_valid_q <= 1'b0;
            state_q    <= S_NEXT;
          end
        end
        S_NEXT: begin
          // Compare before incrementing so the full address range can be
          // dumped without wrapping back to 0.
          if (addr_q == last_q) begin
`ifdef DATA_RAM_UART_DUMP_CHECKSUM_EN
            tx_byte_q  <= chk_q;
            tx_valid_q <= 1'b1;
            state_q    <= S_CHKSUM;
`else
            state_q    <= S_DONE;
`endif
          end else begin
            addr_q     <= addr_q + ADDR_W'(1);
            o_ram_read <= 1'b1;
            state_q    <= S_READ_REQ;
          end
        end
`ifdef DATA_RAM_UART_DUMP_CHECKSUM_EN
        S_CHKSUM: begin
          if (tx_accept) begin
            tx_valid_q <= 1'b0;
            state_q    <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          // The transmitter's ready rises in the last stop-bit cycle, so
          // o_done is registered exactly as that stop bit completes.
          if (o_done) begin
            o_done  <= 1'b0;
            o_busy  <= 1'b0;
            state_q <= S_IDLE;
          end else if (tx_ready) begin
            o_done <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_valid(tx_valid_q),
    .i_byte (tx_byte_q),
    .o_ready(tx_ready),
    .o_tx   (o_tx)
  );

endmodule
